// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch stage and
//   the MEM stage of a pipeline. A request for the memory is called a
//   requester; a requester is granted from IDLE, which starts an access.
//   An access holds the memory for LATENCY cycles, then returns to IDLE.
//   In that IDLE cycle the requester gets a registered one-cycle ready
//   pulse, and the read data is presented with it.
//   Data accesses win ties, but only up to MAX_DM_BURST consecutive grants
//   while a fetch is waiting. After that, the fetch gets the next tie.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request and address
//   if_flush                 branch-taken cancel for the current fetch
//   if_rdata, if_ready       fetched instruction, one-cycle done pulse
//   dm_read, dm_write        MEM-stage load / store request
//   dm_addr, dm_wdata        MEM-stage address and store data
//   dm_rdata, dm_ready       load data, one-cycle done pulse
//   mem_en, mem_we           memory enable / write enable (first cycle only)
//   mem_addr, mem_wdata      memory address / write data (held for the access)
//   mem_rdata                memory read data
//   stall_if, stall_mem      pipeline freeze requests
module mem_arbiter #(
  parameter int LATENCY      = 2,
  parameter int MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [2:0] LAT3   = 3'(LATENCY);
  localparam logic [2:0] BURST3 = 3'(MAX_DM_BURST);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  state_t      state, next_state;
  logic [2:0]  cnt;
  logic [2:0]  dm_streak;
  logic        cancel;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        if_ready_q, dm_ready_q;
  logic [31:0] if_rdata_q, dm_rdata_q;

  logic if_elig, dm_elig, if_pending;
  logic grant_if, grant_dm;
  logic in_acc, first_cyc, last_cyc;

  // Eligibility and arbitration. A requester whose ready pulse is high this
  // cycle has just been served. It is not eligible again until the pipeline
  // has consumed the result. Because of this, the other side gets a ready
  // cycle whenever it is waiting.
  always_comb begin
    if_pending = if_req & ~if_ready_q;
    if_elig    = if_pending & ~if_flush;
    dm_elig    = (dm_read | dm_write) & ~dm_ready_q;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    if (state == IDLE) begin
      if (dm_elig && (!if_elig || dm_streak != BURST3))
        grant_dm = 1'b1;
      else if (if_elig)
        grant_if = 1'b1;
    end
  end

  // The counter is loaded with LATENCY at grant and counts down once per
  // access cycle, so the first cycle is cnt==LATENCY and the last is cnt==1.
  // With LATENCY=1 both are the same cycle.
  always_comb begin
    in_acc    = (state == IF_ACC) || (state == DM_ACC);
    first_cyc = in_acc && (cnt == LAT3);
    last_cyc  = in_acc && (cnt == 3'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_dm)
          next_state = DM_ACC;
        else if (grant_if)
          next_state = IF_ACC;
      end
      IF_ACC, DM_ACC: begin
        if (last_cyc)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. This block latches the request at grant, runs the access
  // counter and the burst counter, and registers the ready/rdata results.
  // A flush seen in any fetch cycle, including the last one, suppresses
  // the fetch result. The memory access itself still runs to the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 3'd0;
      dm_streak  <= 3'd0;
      cancel     <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
            we_q    <= dm_write;
            cnt     <= LAT3;
            if (if_pending && dm_streak != BURST3)
              dm_streak <= dm_streak + 3'd1;
          end else if (grant_if) begin
            addr_q    <= if_addr;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            cnt       <= LAT3;
            cancel    <= 1'b0;
            dm_streak <= 3'd0;
          end
        end
        IF_ACC: begin
          cnt <= cnt - 3'd1;
          if (if_flush)
            cancel <= 1'b1;
          if (last_cyc && !(cancel || if_flush)) begin
            if_ready_q <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
        end
        DM_ACC: begin
          cnt <= cnt - 3'd1;
          if (last_cyc) begin
            dm_ready_q <= 1'b1;
            if (!we_q)
              dm_rdata_q <= mem_rdata;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

  // Outputs. The enable strobes only in the first access cycle. The address
  // and write data come straight from the grant latches, so they stay
  // stable for the whole access.
  always_comb begin
    mem_en    = first_cyc;
    mem_we    = first_cyc & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ready  = if_ready_q;
    if_rdata  = if_rdata_q;
    dm_ready  = dm_ready_q;
    dm_rdata  = dm_rdata_q;
    stall_if  = if_req & ~if_ready_q;
    stall_mem = (dm_read | dm_write) & ~dm_ready_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed testbench for mem_arbiter with default parameters
//   (LATENCY=2, MAX_DM_BURST=4). Each scenario task drives stimulus, then
//   compares the outputs against hand-computed values. A negedge monitor
//   logs the address of every access that starts (every mem_en cycle).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  logic [31:0] grant_log[$];

  mem_arbiter #(.LATENCY(2), .MAX_DM_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the address of every access start, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_en === 1'b1)
      grant_log.push_back(mem_addr);
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    mem_rdata = 32'd0;
    tick(); tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_ready: got %b expected 0", if_ready); end
    checks++; if (dm_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_dm_ready: got %b expected 0", dm_ready); end
    checks++; if (if_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_if_rdata: got %h expected 0", if_rdata); end
    checks++; if (dm_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_dm_rdata: got %h expected 0", dm_rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({stall_if, stall_mem} !== 2'b00) begin errors++; $display("[TB] FAIL reset_stalls: got %b expected 00", {stall_if, stall_mem}); end
    rst = 1'b0;
    tick();
  endtask

  // Single fetch: the enable strobes at cycle 1 and the ready pulse comes at cycle 3.
  task automatic test_if_fetch();
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hA5A5_0001;
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_en_c1: got %b expected 1", mem_en); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h expected 10", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_we: got %b expected 0", mem_we); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_if_c1: got %b expected 1", stall_if); end
    tick();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_en_c2: got %b expected 0", mem_en); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL fetch_if_ready_c2: got %b expected 0", if_ready); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL fetch_mem_addr_hold: got %h expected 10", mem_addr); end
    tick();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_if_ready_c3: got %b expected 1", if_ready); end
    checks++; if (if_rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL fetch_if_rdata: got %h expected a5a50001", if_rdata); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_if_c3: got %b expected 0", stall_if); end
    if_req = 1'b0;
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL fetch_if_ready_c4: got %b expected 0", if_ready); end
    tick();
  endtask

  // Simultaneous fetch and load: the load goes first (ready at cycle 3), then the fetch (ready at cycle 6).
  task automatic test_dm_priority();
    int  dm_cyc;
    int  if_cyc;
    bit  stall_ok;
    grant_log.delete();
    dm_cyc = 0; if_cyc = 0; stall_ok = 1'b1;
    if_req = 1'b1; if_addr = 32'h20; dm_read = 1'b1; dm_addr = 32'h30;
    mem_rdata = 32'h0000_BEEF;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (dm_ready === 1'b1 && dm_cyc == 0) begin
        dm_cyc = c; dm_read = 1'b0; mem_rdata = 32'h1111_2222;
      end
      if (if_ready === 1'b1) begin
        if_cyc = c;
        break;
      end
      if (stall_if !== 1'b1) stall_ok = 1'b0;
    end
    if_req = 1'b0;
    checks++; if (dm_cyc != 3) begin errors++; $display("[TB] FAIL prio_dm_ready_cycle: got %0d expected 3", dm_cyc); end
    checks++; if (if_cyc != 6) begin errors++; $display("[TB] FAIL prio_if_ready_cycle: got %0d expected 6", if_cyc); end
    checks++; if (stall_ok !== 1'b1) begin errors++; $display("[TB] FAIL prio_stall_if_held: got %b expected 1", stall_ok); end
    checks++; if (dm_rdata !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL prio_dm_rdata: got %h expected 0000beef", dm_rdata); end
    checks++; if (if_rdata !== 32'h1111_2222) begin errors++; $display("[TB] FAIL prio_if_rdata: got %h expected 11112222", if_rdata); end
    checks++; if (grant_log.size() != 2 || grant_log[0] !== 32'h30) begin errors++; $display("[TB] FAIL prio_grant_order: got size %0d first %h expected size 2 first 30", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 32'hx); end
    tick(); tick();
  endtask

  // Store with dm_read also high: the write wins, and dm_rdata keeps the last load value.
  task automatic test_dm_write();
    dm_write = 1'b1; dm_read = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234;
    mem_rdata = 32'hDEAD_DEAD;
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL write_mem_en: got %b expected 1", mem_en); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL write_mem_we_c1: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL write_mem_addr: got %h expected 40", mem_addr); end
    checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("[TB] FAIL write_mem_wdata_c1: got %h expected 1234", mem_wdata); end
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("[TB] FAIL write_stall_mem: got %b expected 1", stall_mem); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL write_mem_we_c2: got %b expected 0", mem_we); end
    checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("[TB] FAIL write_mem_wdata_c2: got %h expected 1234", mem_wdata); end
    tick();
    checks++; if (dm_ready !== 1'b1) begin errors++; $display("[TB] FAIL write_dm_ready: got %b expected 1", dm_ready); end
    checks++; if (dm_rdata !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL write_dm_rdata_kept: got %h expected 0000beef", dm_rdata); end
    dm_write = 1'b0; dm_read = 1'b0;
    tick();
    checks++; if (dm_ready !== 1'b0) begin errors++; $display("[TB] FAIL write_dm_ready_c4: got %b expected 0", dm_ready); end
    tick();
  endtask

  // A flush in the second fetch cycle kills the result. The next fetch then uses the new address.
  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h50; mem_rdata = 32'h5555_5555;
    tick();
    checks++; if (mem_addr !== 32'h50) begin errors++; $display("[TB] FAIL flush_first_addr: got %h expected 50", mem_addr); end
    tick();
    if_flush = 1'b1; if_addr = 32'h60;
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_ready: got %b expected 0", if_ready); end
    checks++; if (if_rdata !== 32'h1111_2222) begin errors++; $display("[TB] FAIL flush_rdata_kept: got %h expected 11112222", if_rdata); end
    if_flush = 1'b0;
    tick();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h60) begin errors++; $display("[TB] FAIL flush_refetch: got en %b addr %h expected en 1 addr 60", mem_en, mem_addr); end
    mem_rdata = 32'h6666_6666;
    tick(); tick();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_refetch_ready: got %b expected 1", if_ready); end
    checks++; if (if_rdata !== 32'h6666_6666) begin errors++; $display("[TB] FAIL flush_refetch_rdata: got %h expected 66666666", if_rdata); end
    if_req = 1'b0;
    tick(); tick();
  endtask

  // The fetch is held off by a flush while four loads are granted, so dm_streak
  // reaches 4. Once the flush drops, a tie goes to the fetch. After that the loads resume.
  task automatic test_burst();
    int          dm_done;
    int          flush_drop_at;
    logic [31:0] exp_order[7];
    logic [31:0] got;
    exp_order = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h100, 32'h210, 32'h214};
    grant_log.delete();
    dm_done = 0; flush_drop_at = -1;
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b1;
    dm_read = 1'b1; dm_addr = 32'h200;
    for (int c = 1; c <= 80 && dm_done < 6; c++) begin
      tick();
      if (flush_drop_at == c) if_flush = 1'b0;
      if (if_ready === 1'b1) if_req = 1'b0;
      if (dm_ready === 1'b1) begin
        dm_done++;
        if (dm_done == 4) flush_drop_at = c + 1;
        if (dm_done == 6) dm_read = 1'b0;
        else dm_addr = 32'h200 + 32'(4 * dm_done);
      end
    end
    if_req = 1'b0; if_flush = 1'b0; dm_read = 1'b0;
    checks++; if (dm_done != 6) begin errors++; $display("[TB] FAIL burst_dm_count: got %0d expected 6", dm_done); end
    checks++; if (grant_log.size() != 7) begin errors++; $display("[TB] FAIL burst_grant_count: got %0d expected 7", grant_log.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (grant_log.size() > i) ? grant_log[i] : 32'hFFFF_FFFF;
      checks++; if (got !== exp_order[i]) begin errors++; $display("[TB] FAIL burst_grant_%0d: got %h expected %h", i, got, exp_order[i]); end
    end
    tick(); tick();
  endtask

  // A reset during a load aborts it: no ready pulse and every registered output is cleared.
  task automatic test_reset_mid_access();
    dm_read = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h9999; mem_rdata = 32'h7777_7777;
    tick();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_started: got %b expected 1", mem_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_read = 1'b0;
    checks++; if (dm_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_dm_ready: got %b expected 0", dm_ready); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_mem_en_we: got %b expected 00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (dm_rdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_dm_rdata: got %h expected 0", dm_rdata); end
    checks++; if (if_rdata !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_if_rdata: got %h expected 0", if_rdata); end
    tick();
    checks++; if ({dm_ready, mem_en} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_after: got ready/en %b expected 00", {dm_ready, mem_en}); end
    tick();
  endtask

  initial begin
    $display("[TB] starting mem_arbiter directed tests");
    test_reset();
    test_if_fetch();
    test_dm_priority();
    test_dm_write();
    test_flush();
    test_burst();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
